// File: rtl/mb_ctx_pkg.sv
// mb_ctx_pkg: shared constants, FSM states and line-entry packing for the MB context store
package mb_ctx_pkg;
  localparam logic [7:0] PRED_TOP_INIT = 8'd127;
  localparam logic [7:0] PRED_LEFT_INIT = 8'd129;
  localparam int Y_BOTTOM_OFS = 240;
  localparam int UV_V_OFS = 64;
  localparam int LINE_W = 256;
  typedef enum logic [1:0] {IDLE, RD_TOP, RD_TR, OUT} ctx_state_t;
  // entry layout: [127:0] luma bottom row, [191:128] U row 7, [255:192] V row 7
  function automatic logic [LINE_W-1:0] line_entry(input logic [2047:0] y, input logic [1023:0] uv);
    return {uv[(UV_V_OFS+56)*8 +: 64], uv[56*8 +: 64], y[Y_BOTTOM_OFS*8 +: 128]};
  endfunction
endpackage

// File: rtl/ctx_line_ram.sv
// ctx_line_ram: simple dual-port line buffer, synchronous read-first
module ctx_line_ram
  import mb_ctx_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [LINE_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  output logic [LINE_W-1:0] rd
);
  logic [LINE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/mb_context_store.sv
// mb_context_store: keeps top line buffer and left/corner registers, serves neighbour
// predictor context for the next macroblock
module mb_context_store
  import mb_ctx_pkg::*;
#(
  parameter int MAX_MB_W = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic [9:0]    mb_w,
  input  logic          upd_valid,
  input  logic [9:0]    upd_x,
  input  logic [9:0]    upd_y,
  input  logic [2047:0] y_rec,
  input  logic [1023:0] uv_rec,
  input  logic          req_valid,
  input  logic [9:0]    req_x,
  input  logic [9:0]    req_y,
  output logic          busy,
  output logic          ctx_valid,
  output logic [7:0]    top_left_y,
  output logic [7:0]    top_left_u,
  output logic [7:0]    top_left_v,
  output logic [159:0]  top_y,
  output logic [63:0]   top_u,
  output logic [63:0]   top_v,
  output logic [127:0]  left_y,
  output logic [63:0]   left_u,
  output logic [63:0]   left_v
);
  ctx_state_t state;
  logic [9:0] mbw, rx, ry, cap_x;
  logic line_ok;
  logic [LINE_W-1:0] top_cap, rd_data;
  logic [127:0] ly, col_y;
  logic [63:0] lu, lv, col_u, col_v;
  logic [7:0] cy, cu, cv;
  logic re, tv, lft;
  logic [AW-1:0] ra;
  logic [31:0] tr;
  logic unused;
  assign unused = ^upd_y;
  for (genvar g = 0; g < 16; g++) begin : g_col_y
    assign col_y[g*8 +: 8] = y_rec[(g*16+15)*8 +: 8];
  end
  for (genvar g = 0; g < 8; g++) begin : g_col_uv
    assign col_u[g*8 +: 8] = uv_rec[(g*8+7)*8 +: 8];
    assign col_v[g*8 +: 8] = uv_rec[(UV_V_OFS+g*8+7)*8 +: 8];
  end
  assign re = (state == IDLE && req_valid && !frame_start) || state == RD_TOP;
  assign ra = state == IDLE ? AW'(req_x) : AW'(rx + 10'd1);
  assign tv = ry != 10'd0 && line_ok;
  assign lft = rx != 10'd0;
  // top-right falls back to replicated top byte 15 at the right picture edge
  assign tr = !tv ? {4{PRED_TOP_INIT}} : rx == mbw - 10'd1 ? {4{top_cap[127:120]}} : rd_data[31:0];
  ctx_line_ram #(.DEPTH(MAX_MB_W), .AW(AW)) u_ram (
    .clk(clk),
    .we(upd_valid),
    .wa(AW'(upd_x)),
    .wd(line_entry(y_rec, uv_rec)),
    .re(re),
    .ra(ra),
    .rd(rd_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {mbw, rx, ry, cap_x, line_ok, top_cap} <= '0;
      {ly, lu, lv, cy, cu, cv} <= '0;
      {busy, ctx_valid, top_left_y, top_left_u, top_left_v} <= '0;
      {top_y, top_u, top_v, left_y, left_u, left_v} <= '0;
    end else begin
      ctx_valid <= 1'b0;
      if (frame_start) begin
        mbw <= mb_w;
        line_ok <= 1'b0;
        {ly, lu, lv, cy, cu, cv} <= '0;
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        if (upd_valid) begin
          line_ok <= 1'b1;
          ly <= col_y;
          lu <= col_u;
          lv <= col_v;
          // the captured top entry of this column is about to be overwritten; keep its corner
          if (upd_x == cap_x) {cy, cu, cv} <= {top_cap[127:120], top_cap[191:184], top_cap[255:248]};
        end
        case (state)
          IDLE: if (req_valid) begin
            rx <= req_x;
            ry <= req_y;
            busy <= 1'b1;
            state <= RD_TOP;
          end
          RD_TOP: begin
            top_cap <= rd_data;
            cap_x <= rx;
            state <= RD_TR;
          end
          RD_TR: begin
            top_y <= {tr, tv ? top_cap[127:0] : {16{PRED_TOP_INIT}}};
            top_u <= tv ? top_cap[191:128] : {8{PRED_TOP_INIT}};
            top_v <= tv ? top_cap[255:192] : {8{PRED_TOP_INIT}};
            left_y <= lft ? ly : {16{PRED_LEFT_INIT}};
            left_u <= lft ? lu : {8{PRED_LEFT_INIT}};
            left_v <= lft ? lv : {8{PRED_LEFT_INIT}};
            top_left_y <= !tv ? PRED_TOP_INIT : !lft ? PRED_LEFT_INIT : cy;
            top_left_u <= !tv ? PRED_TOP_INIT : !lft ? PRED_LEFT_INIT : cu;
            top_left_v <= !tv ? PRED_TOP_INIT : !lft ? PRED_LEFT_INIT : cv;
            ctx_valid <= 1'b1;
            state <= OUT;
          end
          default: begin
            busy <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
